wb_uart_tx_slave: RTL and testbench

Wishbone classic slave UART transmitter, 8N1 framing. Responds to the picorv32 SoC Wishbone initiator. Buffers written bytes in a small FIFO and serialises them onto a GPIO pin. Forms the transmit-side counterpart to the host-facing uart_rx path. Intended for the DE1 board GPIO_1 header.

---
 rtl/wb_uart_tx_slave.sv | 157 +++++++++++++++
 tb/tb_wb_uart_tx_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_slave.sv
// Wishbone classic slave UART transmitter (8N1): byte FIFO in front of a
// start/data/stop serialiser, with a status register and a tx-done interrupt.
module wb_uart_tx_slave #(
    parameter int unsigned DIVISOR = 87,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        uart_tx,
    output logic        irq_o
);

    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = 16;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [PW-1:0]   wr_ptr, rd_ptr, level;
    logic [7:0]      mem [DEPTH];
    logic            overflow;
    logic            empty, full, bit_end;
    logic            req, push_req, clr_ovf, push_ok, drop;
    logic            pop_c, shift_c, tx_c;
    logic [31:0]     status_c;
    logic            unused;

    assign unused = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    // Bus decode: a request is the first cycle of cyc&stb not yet acked
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign push_req = req & wb_we_i & ~wb_adr_i[2] & wb_sel_i[0];
    assign clr_ovf  = req & wb_we_i & wb_adr_i[2] & wb_dat_i[3];

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == PW'(DEPTH));
    assign bit_end = (baud_cnt == BAUD_LAST);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok = push_req & (~full | pop_c);
    assign drop    = push_req & full & ~pop_c;

    always_comb begin
        status_c             = '0;
        status_c[0]          = full;
        status_c[1]          = empty;
        status_c[2]          = (state != S_IDLE);
        status_c[3]          = overflow;
        status_c[8 +: PW]    = level;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_START;
            S_START: if (bit_end) state_nx = S_DATA;
            S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = S_STOP;
            S_STOP:  if (bit_end) state_nx = empty ? S_IDLE : S_START;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic: FIFO pop, shift and next serial level
    always_comb begin
        pop_c   = 1'b0;
        shift_c = 1'b0;
        tx_c    = uart_tx;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop_c = 1'b1;
                    tx_c  = 1'b0;
                end
            end
            S_START: if (bit_end) tx_c = shreg[0];
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        tx_c = 1'b1;
                    end else begin
                        shift_c = 1'b1;
                        tx_c    = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end && !empty) begin
                    pop_c = 1'b1;
                    tx_c  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wb_dat_i[7:0];
    end

    // Serialiser, FIFO pointers and bus response registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
            uart_tx  <= 1'b1;
            irq_o    <= 1'b1;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)   rd_ptr <= rd_ptr + PW'(1);

            if (state == S_IDLE || bit_end) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + CW'(1);

            if (state != S_DATA) bit_cnt <= '0;
            else if (bit_end)    bit_cnt <= bit_cnt + 3'd1;

            if (pop_c)        shreg <= mem[rd_ptr[FIFO_AW-1:0]];
            else if (shift_c) shreg <= {1'b0, shreg[7:1]};

            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            uart_tx  <= tx_c;
            irq_o    <= empty & (state == S_IDLE);
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i && wb_adr_i[2]) ? status_c : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx_slave.sv
// Randomized bench for wb_uart_tx_slave: byte-queue reference model plus a
// line monitor that decodes every frame and checks its exact bit timing.
module tb_wb_uart_tx_slave;

    localparam int DIV = 4;
    localparam int FW  = 10 * DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        uart_tx;
    logic        irq_o;

    wb_uart_tx_slave #(.DIVISOR(DIV), .FIFO_AW(4)) dut (
        .clock(clk), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .uart_tx(uart_tx), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;

    // Reference model: bytes accepted but not yet started on the line
    logic [7:0] exp_q[$];
    logic       ovf_exp = 1'b0;
    logic [31:0] burst_q[$];
    int         last_ack_cyc = 0;

    // Line monitor state
    logic          mon_active = 1'b0;
    int            mon_cnt = 0;
    logic [FW-1:0] frame;
    logic [7:0]    cur_exp;
    int            frames_started = 0;
    int            frames_done = 0;
    int            start_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [7:0] b);
        logic [FW-1:0] f;
        logic lvl;
        for (int s = 0; s < 10; s++) begin
            lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
            for (int c = 0; c < DIV; c++) f[s*DIV + c] = lvl;
        end
        return f;
    endfunction

    function automatic logic [31:0] status_exp(input logic busy);
        int lvl;
        lvl = exp_q.size();
        return 32'((lvl << 8) | (int'(ovf_exp) << 3) | (int'(busy) << 2) |
                   (int'(lvl == 0) << 1) | int'(lvl == 16));
    endfunction

    task automatic model_write(input logic [2:0] adr, input logic [3:0] sel, input logic [31:0] d);
        if (!adr[2]) begin
            if (sel[0]) begin
                if (exp_q.size() < 16) exp_q.push_back(d[7:0]);
                else                   ovf_exp = 1'b1;
            end
        end else if (d[3]) begin
            ovf_exp = 1'b0;
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            frame[mon_cnt] = uart_tx;
            mon_cnt++;
            if (mon_cnt == FW) begin
                check("frame", 64'(frame), 64'(frame_of(cur_exp)));
                frames_done++;
                mon_active = 1'b0;
            end
        end else if (uart_tx == 1'b0) begin
            mon_active = 1'b1;
            frame[0]   = 1'b0;
            mon_cnt    = 1;
            frames_started++;
            start_q.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
                cur_exp = 8'h00;
            end else begin
                cur_exp = exp_q.pop_front();
            end
        end
    end

    // Writes every word of burst_q with cyc/stb held throughout
    task automatic wb_burst(input logic [2:0] adr, input logic [3:0] sel);
        int n, idx;
        n   = burst_q.size();
        idx = 0;
        wb_adr_i = adr; wb_sel_i = sel; wb_we_i = 1'b1;
        wb_dat_i = burst_q[0];
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int k = 1; k <= 2 * n; k++) begin
            @(negedge clk);
            check("ack_pattern", 64'(wb_ack_o), 64'(k % 2));
            if (wb_ack_o === 1'b1 && idx < n) begin
                model_write(adr, sel, wb_dat_i);
                last_ack_cyc = cyc_cnt;
                idx++;
                if (idx < n) wb_dat_i = burst_q[idx];
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        burst_q.delete();
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] d);
        wb_adr_i = adr; wb_sel_i = 4'hF; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        check("rd_ack", 64'(wb_ack_o), 64'd1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check("rd_dat_idle", 64'(wb_dat_o), 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_active) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(k < budget), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        int base, n, s0, sz;

        // Reset values
        #12;
        check("rst_tx", 64'(uart_tx), 64'd1);
        check("rst_ack", 64'(wb_ack_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd1);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wb_read(3'h4, d);
        check("status_after_rst", 64'(d), 64'h2);
        check("irq_idle", 64'(irq_o), 64'd1);

        // Single 0x55 frame, one-cycle pop latency
        burst_q.push_back(32'h55);
        wb_burst(3'h0, 4'h1);
        repeat (5) @(negedge clk);
        check("start_latency", 64'(start_q[$] - last_ack_cyc), 64'd1);
        check("irq_busy", 64'(irq_o), 64'd0);
        wb_read(3'h4, d);
        check("status_busy", 64'(d), 64'(status_exp(1'b1)));
        wait_drain(200);
        check("irq_done", 64'(irq_o), 64'd1);

        // Three back-to-back frames must be contiguous
        burst_q = '{32'hA5, 32'h00, 32'hFF};
        wb_burst(3'h0, 4'h1);
        wait_drain(400);
        sz = start_q.size();
        check("gap_1", 64'(start_q[sz-2] - start_q[sz-3]), 64'(FW));
        check("gap_2", 64'(start_q[sz-1] - start_q[sz-2]), 64'(FW));

        // Fill while a frame is in flight, then overflow by two
        base = frames_done;
        for (int i = 0; i < 19; i++) burst_q.push_back($urandom & 32'hFF);
        wb_burst(3'h0, 4'h1);
        wb_read(3'h4, d);
        check("status_full_ovf", 64'(d), 64'(status_exp(1'b1)));
        check("full_ovf_bits", 64'(d[3:0]), 64'hD);
        burst_q.push_back(32'h8);
        wb_burst(3'h4, 4'h1);
        wait_drain(17 * FW + 200);
        check("fill_frames", 64'(frames_done - base), 64'd17);
        wb_read(3'h4, d);
        check("status_ovf_clr", 64'(d), 64'h2);

        // Held strobe for six cycles gives three pushes
        for (int i = 0; i < 3; i++) burst_q.push_back($urandom & 32'hFF);
        wb_burst(3'h0, 4'h1);
        repeat (3) @(negedge clk);
        wb_read(3'h4, d);
        check("held_level", 64'(d[12:8]), 64'd2);
        check("held_status", 64'(d), 64'(status_exp(1'b1)));
        burst_q.push_back(32'h7E);
        wb_burst(3'h0, 4'hE);
        wb_read(3'h4, d);
        check("nosel_level", 64'(d[12:8]), 64'd2);
        wb_read(3'h0, d);
        check("txdata_read", 64'(d), 64'd0);
        wait_drain(4 * FW);

        // Randomized bursts with random byte selects
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) burst_q.push_back($urandom);
            wb_burst(3'h0, 4'($urandom));
            repeat ($urandom_range(20, 60)) @(negedge clk);
        end
        wait_drain(20 * FW);
        check("rand_started_done", 64'(frames_started - frames_done), 64'd0);
        wb_read(3'h4, d);
        check("rand_status", 64'(d), 64'h2);

        // Reset in the middle of data bit 4
        burst_q = '{32'h00, 32'h3C};
        wb_burst(3'h0, 4'h1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (mon_active && mon_cnt >= 5 * DIV + 2) break;
        end
        check("reset_point_timeout", 64'(n < 200), 64'd1);
        check("tx_pre_reset", 64'(uart_tx), 64'd0);
        reset_n = 1'b0;
        exp_q.delete();
        ovf_exp = 1'b0;
        #1;
        check("tx_async_reset", 64'(uart_tx), 64'd1);
        check("irq_async_reset", 64'(irq_o), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wb_read(3'h4, d);
        check("status_post_reset", 64'(d), 64'h2);
        s0 = frames_started;
        repeat (3 * FW) @(negedge clk);
        check("no_frame_after_reset", 64'(frames_started - s0), 64'd0);
        check("tx_idle_after_reset", 64'(uart_tx), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
